rvfi_check_sequencer: RTL and testbench

Single-shot trigger/check sequencer for the RVFI formal checkers (unique, ordering, liveness style). After reset it counts cycles, opens a trigger window, and fires `trig` on the first retirement on the checked channel inside that window. It latches that instruction's `rvfi_order` and pulses `check` exactly once at the bounded depth. It sits between the RVFI bus of the core wrapper and one or more checker instances, replacing ad-hoc cycle-counter logic in each testbench.

---
 rtl/rvfi_check_sequencer.sv | 134 +++++++++++++
 tb/tb_rvfi_check_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_check_sequencer.sv
// Purpose: single-shot trigger/check sequencer for RVFI formal checkers.
//          Counts cycles from reset and opens a trigger window. It fires trig on
//          the first retirement on the checked channel, then pulses check once
//          at DEPTH.
// Latency: trig is combinational from rvfi_valid (same cycle). trig_order and
//          trig_cycle update on the edge ending the trig cycle. check is
//          registered and is high during cycle DEPTH.
// Backpressure: none. The RVFI bus is observed only and never stalled.
// Ports:   clock, reset (sync, active-high); rvfi_valid[NRET]; rvfi_order[64*NRET];
//          trig, check, trig_order[64], trig_cycle[CW], cycle[CW], done, miss.
module rvfi_check_sequencer #(
    parameter int NRET        = 1,
    parameter int CHANNEL_IDX = 0,
    parameter int SKIP        = 0,
    parameter int DEPTH       = 20,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    output logic                 trig,
    output logic                 check,
    output logic [63:0]          trig_order,
    output logic [CW-1:0]        trig_cycle,
    output logic [CW-1:0]        cycle,
    output logic                 done,
    output logic                 miss
);

    typedef enum logic [2:0] {
        WARMUP = 3'd0,
        ARMED  = 3'd1,
        HOLD   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Last cycle index of each phase; transitions happen on the edge leaving it.
    localparam logic [CW-1:0] SKIP_LAST  = CW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CW-1:0] DEPTH_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_SAT  = CW'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic        sel_valid;
    logic [63:0] sel_order;
    logic        miss_set;

    assign sel_valid = rvfi_valid[CHANNEL_IDX];
    assign sel_order = rvfi_order[64*CHANNEL_IDX +: 64];

    // Other channels are deliberately not observed.
    logic unused_inputs;
    assign unused_inputs = ^{rvfi_valid, rvfi_order};

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            if (SKIP > 0) begin
                state <= WARMUP;
            end else begin
                state <= ARMED;
            end
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            WARMUP: begin
                if (cycle == SKIP_LAST) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (sel_valid) begin
                    // A trigger in the last window cycle goes straight to CHECK.
                    state_next = (cycle == DEPTH_LAST) ? CHECK : HOLD;
                end else if (cycle == DEPTH_LAST) begin
                    state_next = DONE;
                end
            end
            HOLD: begin
                if (cycle == DEPTH_LAST) begin
                    state_next = CHECK;
                end
            end
            CHECK:   state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = DONE;
        endcase
    end

    // Output logic. trig is gated by reset so a valid held through reset cannot
    // leak a trigger in the reset cycle.
    always_comb begin
        trig     = 1'b0;
        miss_set = 1'b0;
        if (!reset && state == ARMED) begin
            trig     = sel_valid;
            miss_set = !sel_valid && (cycle == DEPTH_LAST);
        end
    end

    // Cycle counter, captured trigger data and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle      <= '0;
            trig_order <= '0;
            trig_cycle <= '0;
            check      <= 1'b0;
            done       <= 1'b0;
            miss       <= 1'b0;
        end else begin
            if (cycle != DEPTH_SAT) begin
                cycle <= cycle + CW'(1);
            end
            if (trig) begin
                trig_order <= sel_order;
                trig_cycle <= cycle;
            end
            check <= (state_next == CHECK);
            done  <= (state_next == DONE);
            if (miss_set) begin
                miss <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Purpose: directed and random checks of rvfi_check_sequencer in three
//          configurations against a per-sequence reference model.
// Latency: sampled on the falling edge. Inputs are driven 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_rvfi_check_sequencer;

    localparam int CW_A = $clog2(10 + 1);
    localparam int CW_C = $clog2(4 + 1);

    // Per-instance configuration: 0 = A (SKIP2/DEPTH10), 1 = B (NRET2, ch1),
    // 2 = C (SKIP0/DEPTH4).
    int P_SKIP  [3] = '{2, 2, 0};
    int P_DEPTH [3] = '{10, 10, 4};
    int P_CH    [3] = '{0, 1, 0};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst_a, rst_b, rst_c;
    logic [0:0]        vld_a;
    logic [1:0]        vld_b;
    logic [0:0]        vld_c;
    logic [63:0]       ord_a, ord_c;
    logic [127:0]      ord_b;
    logic              trig_a, trig_b, trig_c;
    logic              check_a, check_b, check_c;
    logic [63:0]       torder_a, torder_b, torder_c;
    logic [CW_A-1:0]   tcyc_a, tcyc_b, cycle_a, cycle_b;
    logic [CW_C-1:0]   tcyc_c, cycle_c;
    logic              done_a, done_b, done_c;
    logic              miss_a, miss_b, miss_c;

    rvfi_check_sequencer #(.NRET(1), .CHANNEL_IDX(0), .SKIP(2), .DEPTH(10)) dut_a (
        .clock(clock), .reset(rst_a), .rvfi_valid(vld_a), .rvfi_order(ord_a),
        .trig(trig_a), .check(check_a), .trig_order(torder_a), .trig_cycle(tcyc_a),
        .cycle(cycle_a), .done(done_a), .miss(miss_a)
    );

    rvfi_check_sequencer #(.NRET(2), .CHANNEL_IDX(1), .SKIP(2), .DEPTH(10)) dut_b (
        .clock(clock), .reset(rst_b), .rvfi_valid(vld_b), .rvfi_order(ord_b),
        .trig(trig_b), .check(check_b), .trig_order(torder_b), .trig_cycle(tcyc_b),
        .cycle(cycle_b), .done(done_b), .miss(miss_b)
    );

    rvfi_check_sequencer #(.NRET(1), .CHANNEL_IDX(0), .SKIP(0), .DEPTH(4)) dut_c (
        .clock(clock), .reset(rst_c), .rvfi_valid(vld_c), .rvfi_order(ord_c),
        .trig(trig_c), .check(check_c), .trig_order(torder_c), .trig_cycle(tcyc_c),
        .cycle(cycle_c), .done(done_c), .miss(miss_c)
    );

    // Outputs of the instance currently under test
    int          cur;
    logic        s_trig, s_check, s_done, s_miss;
    logic [63:0] s_order, s_tcyc, s_cycle;

    always_comb begin
        s_trig  = trig_a;
        s_check = check_a;
        s_done  = done_a;
        s_miss  = miss_a;
        s_order = torder_a;
        s_tcyc  = 64'(tcyc_a);
        s_cycle = 64'(cycle_a);
        if (cur == 1) begin
            s_trig  = trig_b;
            s_check = check_b;
            s_done  = done_b;
            s_miss  = miss_b;
            s_order = torder_b;
            s_tcyc  = 64'(tcyc_b);
            s_cycle = 64'(cycle_b);
        end else if (cur == 2) begin
            s_trig  = trig_c;
            s_check = check_c;
            s_done  = done_c;
            s_miss  = miss_c;
            s_order = torder_c;
            s_tcyc  = 64'(tcyc_c);
            s_cycle = 64'(cycle_c);
        end
    end

    // Per-cycle stimulus pattern for one sequence
    logic [1:0]  pv  [64];
    logic [63:0] po0 [64];
    logic [63:0] po1 [64];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic [1:0] v, input logic [63:0] o0,
                         input logic [63:0] o1);
        case (inst)
            0: begin vld_a = v[0:0]; ord_a = o0; end
            1: begin vld_b = v; ord_b = {o1, o0}; end
            default: begin vld_c = v[0:0]; ord_c = o0; end
        endcase
    endtask

    task automatic set_rst(input int inst, input logic val);
        case (inst)
            0: rst_a = val;
            1: rst_b = val;
            default: rst_c = val;
        endcase
    endtask

    task automatic clear_pat();
        for (int c = 0; c < 64; c++) begin
            pv[c]  = 2'b00;
            po0[c] = 64'd0;
            po1[c] = 64'd0;
        end
    endtask

    // Hold reset for ncyc cycles with every valid high. trig must stay low, and
    // after the first reset edge every output must be back at its reset value.
    task automatic do_reset(input int inst, input int ncyc);
        cur = inst;
        set_rst(inst, 1'b1);
        drive(inst, 2'b11, {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            chk($sformatf("rst%0d.%0d trig", inst, i), 64'(s_trig), 64'd0);
            if (i > 0) begin
                chk($sformatf("rst%0d.%0d check", inst, i), 64'(s_check), 64'd0);
                chk($sformatf("rst%0d.%0d done", inst, i), 64'(s_done), 64'd0);
                chk($sformatf("rst%0d.%0d miss", inst, i), 64'(s_miss), 64'd0);
                chk($sformatf("rst%0d.%0d cycle", inst, i), s_cycle, 64'd0);
                chk($sformatf("rst%0d.%0d order", inst, i), s_order, 64'd0);
            end
            @(posedge clock);
            #1;
        end
        set_rst(inst, 1'b0);
        drive(inst, 2'b00, 64'd0, 64'd0);
    endtask

    // Run n cycles of the pattern from cycle 0. The model: the trigger is the
    // first valid on the checked channel in window [SKIP, DEPTH-1]. Every other
    // output follows from that cycle and the cycle number.
    task automatic run_seq(input int inst, input int n, input string name);
        int          sk = P_SKIP[inst];
        int          d  = P_DEPTH[inst];
        int          ch = P_CH[inst];
        int          tc = -1;
        logic [63:0] to = 64'd0;
        logic        hit;
        cur = inst;
        for (int c = sk; c < n && c <= d - 1; c++) begin
            if (tc < 0 && pv[c][ch]) tc = c;
        end
        if (tc >= 0) to = (ch == 1) ? po1[tc] : po0[tc];
        for (int c = 0; c < n; c++) begin
            drive(inst, pv[c], po0[c], po1[c]);
            hit = (tc >= 0);
            @(negedge clock);
            chk($sformatf("%s c%0d trig", name, c), 64'(s_trig), 64'(hit && c == tc));
            chk($sformatf("%s c%0d check", name, c), 64'(s_check), 64'(hit && c == d));
            chk($sformatf("%s c%0d order", name, c), s_order,
                (hit && c > tc) ? to : 64'd0);
            chk($sformatf("%s c%0d tcyc", name, c), s_tcyc,
                (hit && c > tc) ? 64'(tc) : 64'd0);
            chk($sformatf("%s c%0d cycle", name, c), s_cycle, 64'((c < d) ? c : d));
            chk($sformatf("%s c%0d done", name, c), 64'(s_done),
                64'(hit ? (c > d) : (c >= d)));
            chk($sformatf("%s c%0d miss", name, c), 64'(s_miss), 64'(!hit && c >= d));
            @(posedge clock);
            #1;
        end
        drive(inst, 2'b00, 64'd0, 64'd0);
    endtask

    initial begin
        cur   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        vld_a = '0;
        vld_b = '0;
        vld_c = '0;
        ord_a = '0;
        ord_b = '0;
        ord_c = '0;

        // Valids at 1, 3, 5: only cycle 3 is inside the window and first.
        do_reset(0, 2);
        clear_pat();
        pv[1] = 2'b01; po0[1] = 64'd7;
        pv[3] = 2'b01; po0[3] = 64'd9;
        pv[5] = 2'b01; po0[5] = 64'd11;
        run_seq(0, 14, "a_dir");

        // No valid: miss path, counter saturation
        do_reset(0, 1);
        clear_pat();
        run_seq(0, 14, "a_miss");

        // Channel 0 valid never triggers, channel 1 does
        do_reset(1, 2);
        clear_pat();
        pv[2] = 2'b01; po0[2] = 64'h33;
        pv[4] = 2'b10; po1[4] = 64'h55; po0[4] = 64'h66;
        run_seq(1, 14, "b_chan");

        // SKIP=0: trigger at cycle 0, and at DEPTH-1 straight into check
        do_reset(2, 2);
        clear_pat();
        pv[0] = 2'b01; po0[0] = {$urandom, $urandom};
        run_seq(2, 7, "c_c0");
        do_reset(2, 1);
        clear_pat();
        pv[3] = 2'b01; po0[3] = {$urandom, $urandom};
        run_seq(2, 7, "c_c3");

        // Reset mid-sequence after a trigger, then a fresh sequence
        do_reset(0, 1);
        clear_pat();
        pv[3] = 2'b01; po0[3] = 64'd123;
        run_seq(0, 6, "a_pre");
        do_reset(0, 1);
        clear_pat();
        pv[4] = 2'b01; po0[4] = 64'hABCD;
        pv[6] = 2'b01; po0[6] = 64'hEF;
        run_seq(0, 14, "a_post");

        // Valid held high throughout: one trig at SKIP, one check at DEPTH
        do_reset(0, 1);
        clear_pat();
        for (int c = 0; c < 14; c++) begin
            pv[c]  = 2'b11;
            po0[c] = 64'(c + 100);
        end
        run_seq(0, 14, "a_hold");

        // Random sequences on all three configurations
        for (int r = 0; r < 8; r++) begin
            for (int inst = 0; inst < 3; inst++) begin
                do_reset(inst, 1);
                for (int c = 0; c < 64; c++) begin
                    pv[c]  = {1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0)};
                    po0[c] = {$urandom, $urandom};
                    po1[c] = {$urandom, $urandom};
                end
                run_seq(inst, P_DEPTH[inst] + 3, $sformatf("rnd%0d_%0d", r, inst));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
